// File: rtl/uart_rx_fifo.sv
// UART receive buffer: one push per UART byte handshake, DEPTH-entry show-ahead FIFO, sticky overrun.
// Define UART_RX_FIFO_IRQ_EN to add the threshold input and registered irq output.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 raw_clk,
  input  logic                 reset,
  input  logic [7:0]           uart_rx_data,
  input  logic                 uart_rx_ready,
  output logic                 uart_rx_ready_clear,
  input  logic                 pop,
  output logic [7:0]           data_out,
  output logic                 not_empty,
  output logic                 full,
  output logic [ADDR_BITS:0]   count,
  output logic                 overrun,
  input  logic                 overrun_clear
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  input  logic [ADDR_BITS:0]   threshold,
  output logic                 irq
`endif
);

  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_capture;
  logic                   w_pop;
  logic                   w_can_accept;
  logic                   w_push;
  logic                   w_drop;
  logic [ADDR_BITS:0]     w_count_next;
  logic                   w_overrun_next;

  logic [7:0]             r_mem [DEPTH];
  logic [ADDR_BITS-1:0]   r_wptr;
  logic [ADDR_BITS-1:0]   r_rptr;
  logic [ADDR_BITS:0]     r_count;
  logic                   r_overrun;
  logic                   r_ack;
  logic                   r_full;
  logic                   r_not_empty;

  // WAIT holds off re-capture until the UART drops rx_ready, so a long-held byte is pushed once.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (uart_rx_ready) begin
          w_capture    = 1'b1;
          w_state_next = S_ACK;
        end
      end
      S_ACK:   w_state_next = S_WAIT;
      S_WAIT:  if (!uart_rx_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop          = pop && (r_count != '0);
    w_can_accept   = (r_count < FULL_COUNT) || w_pop;
    w_push         = w_capture && w_can_accept;
    w_drop         = w_capture && !w_can_accept;
    w_overrun_next = w_drop || (r_overrun && !overrun_clear);
    w_count_next   = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (ADDR_BITS + 1)'(1);
      2'b01:   w_count_next = r_count - (ADDR_BITS + 1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overrun   <= 1'b0;
      r_ack       <= 1'b0;
      r_full      <= 1'b0;
      r_not_empty <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      if (w_push) r_wptr <= r_wptr + ADDR_BITS'(1);
      if (w_pop)  r_rptr <= r_rptr + ADDR_BITS'(1);
      r_count     <= w_count_next;
      r_overrun   <= w_overrun_next;
      r_ack       <= w_capture;
      r_full      <= (w_count_next == FULL_COUNT);
      r_not_empty <= (w_count_next != '0);
    end
  end

  // Storage is deliberately left out of reset; empty is tracked by count alone.
  always_ff @(posedge raw_clk) begin
    if (w_push) r_mem[r_wptr] <= uart_rx_data;
  end

  assign data_out            = r_not_empty ? r_mem[r_rptr] : 8'h00;
  assign not_empty           = r_not_empty;
  assign full                = r_full;
  assign count               = r_count;
  assign overrun             = r_overrun;
  assign uart_rx_ready_clear = r_ack;

`ifdef UART_RX_FIFO_IRQ_EN
  logic r_irq;

  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= ((w_count_next >= threshold) && (threshold != '0)) || w_overrun_next;
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer between the UART receiver's rx_data/rx_ready/rx_ready_clear handshake and the CPU peripheral register file.
- Takes each received byte, acknowledges it to the UART at once, and queues it in a DEPTH-entry FIFO.
- The CPU drains the FIFO through the peripheral RX data register. Bytes are no longer lost when software is slow to read.
- Overflow is reported through a sticky overrun flag.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, minimum 2.
- ADDR_BITS, 4, log2(DEPTH); pointer width.

Ports:
- raw_clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. All state clears immediately while low.
- uart_rx_data  input  8  byte from the UART receiver; valid while uart_rx_ready=1.
- uart_rx_ready  input  1  UART byte-available level.
- uart_rx_ready_clear  output  1  one-cycle acknowledge pulse back to the UART.
- pop  input  1  one-cycle request from the peripheral register read to remove the head entry.
- data_out  output  8  head entry (show-ahead); 0 when empty.
- not_empty  output  1  count != 0.
- full  output  1  count == DEPTH.
- count  output  ADDR_BITS+1  number of stored bytes, 0..DEPTH.
- overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
- overrun_clear  input  1  clears overrun.

Behaviour:
- Reset (reset=0, asynchronous): the following are all 0:
  - read and write pointers, count, overrun, uart_rx_ready_clear;
  - capture state = IDLE.
- Storage contents are not reset. data_out shows 0 whenever count==0.
- Capture FSM states:
  - IDLE: if uart_rx_ready=1, act on the byte this cycle, then go to ACK. Acting on the byte means:
    - if the FIFO can accept, write uart_rx_data at wptr;
    - otherwise drop the byte and set overrun.
  - ACK: assert uart_rx_ready_clear=1 for exactly this one cycle, then go to WAIT.
  - WAIT: stay while uart_rx_ready=1. When uart_rx_ready=0, go to IDLE.
- The FSM guarantees one push per UART byte, regardless of how long the UART holds rx_ready.
- Accept rule: the FIFO can accept when (count < DEPTH) or (pop=1 and count != 0) in the same cycle.
- Push timing: the written byte is counted on the same edge. It appears on data_out the next cycle if it is the new head.
- Pop: when pop=1 and count != 0, rptr advances and count decrements. The new head is visible the next cycle.
- Pop while empty: ignored. Pointers, count and overrun are unchanged; this is not an error.
- Simultaneous push and pop: both take effect and count is unchanged. Applies at count=DEPTH too (no drop, no overrun).
- Wrap-around: pointers are ADDR_BITS wide and wrap modulo DEPTH naturally. full/empty are derived from count, not from pointer compare.
- overrun:
  - set by a dropped byte;
  - cleared by overrun_clear=1;
  - if both happen in the same cycle, set wins.
- Outputs are registered, except data_out, which is a combinational read of the head entry gated by not_empty.
- Reset mid-operation returns the block to IDLE and empty immediately. If the UART still holds uart_rx_ready=1 after reset deasserts, that byte is captured once.

Optional Feature:
- Macro: UART_RX_FIFO_IRQ_EN.
- When defined, two extra ports are added:
  - threshold, input, ADDR_BITS+1 bits;
  - irq, output, 1 bit.
- irq is registered. It is 1 when count >= threshold and threshold != 0, or when overrun=1. irq resets to 0.
- When not defined, neither port exists and there is no irq logic. All other behaviour is identical.

Test Plan:
- Single byte: after reset, uart_rx_data=0x41 with uart_rx_ready held high 20 cycles.
  - Exactly one uart_rx_ready_clear pulse.
  - count=1, data_out=0x41, not_empty=1.
  - pop -> count=0, data_out=0.
- Fill and overrun (DEPTH=16): push 0x00..0x0F -> full=1, count=16. Push 0x10:
  - ack pulse still issued;
  - overrun=1, count stays 16;
  - popping 16 times returns 0x00..0x0F in order.
- Simultaneous push/pop at full: count=16, pop asserted in the same cycle that 0x55 is captured.
  - count stays 16, overrun stays 0.
  - 0x55 is the last byte popped.
- Wrap-around: 40 interleaved push/pop of incrementing bytes with count never above 3.
  - Output sequence matches input.
  - Pointers wrap twice.
- Pop on empty and overrun_clear: pop with count=0 -> no change.
  - overrun_clear while overrun=1 -> 0 next cycle.
  - overrun_clear coincident with a dropped byte -> overrun stays 1.
- Async reset mid-stream: reset=0 asserted between clock edges with count=5.
  - count=0, overrun=0, uart_rx_ready_clear=0 immediately, before the next edge.
  - With UART_RX_FIFO_IRQ_EN and threshold=4: irq rises the cycle after the 4th push.
